// File: rtl/valu_lane_sequencer.sv
// Sequences a packed vector operation through one external scalar ALU, one lane per cycle,
// collecting per-lane results and flags and pulsing done when the whole vector is written.
module valu_lane_sequencer #(
  parameter int data_size = 8,
  parameter int lanes     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [2:0]                   op_select,
  input  logic [lanes*data_size-1:0]   vec_a,
  input  logic [lanes*data_size-1:0]   vec_b,
  input  logic [lanes-1:0]             lane_mask,
  output logic                         busy,
  output logic                         done,
  output logic [lanes*data_size-1:0]   vec_result,
  output logic [lanes-1:0]             neg_flags,
  output logic [lanes-1:0]             zero_flags,
  output logic [2:0]                   alu_op_select,
  output logic [data_size-1:0]         alu_operand1,
  output logic [data_size-1:0]         alu_operand2,
  input  logic [data_size-1:0]         alu_result,
  input  logic                         alu_neg_flag,
  input  logic                         alu_zero_flag
);

  // state | meaning
  // IDLE  | waiting for start; ALU inputs forced to zero
  // ISSUE | lane idx presented to the ALU, written back on each edge
  // DONE  | all lanes written; done pulses for this single cycle
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int idx_w = (lanes > 1) ? $clog2(lanes) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(lanes - 1);

  logic [1:0]                 state;
  logic [idx_w-1:0]           idx;
  logic [2:0]                 op_q;
  logic [lanes*data_size-1:0] a_q;
  logic [lanes*data_size-1:0] b_q;
  logic [lanes-1:0]           mask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mask_q     <= '0;
      vec_result <= '0;
      neg_flags  <= '0;
      zero_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q       <= op_select;
            a_q        <= vec_a;
            b_q        <= vec_b;
            mask_q     <= lane_mask;
            vec_result <= '0;
            neg_flags  <= '0;
            zero_flags <= '0;
            idx        <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Masked-off lanes pass operand A through with cleared flags.
          if (mask_q[idx]) begin
            vec_result[idx*data_size +: data_size] <= alu_result;
            neg_flags[idx]  <= alu_neg_flag;
            zero_flags[idx] <= alu_zero_flag;
          end else begin
            vec_result[idx*data_size +: data_size] <= a_q[idx*data_size +: data_size];
            neg_flags[idx]  <= 1'b0;
            zero_flags[idx] <= 1'b0;
          end
          if (idx == last_idx) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    alu_op_select = 3'b000;
    alu_operand1  = '0;
    alu_operand2  = '0;
    if (state == ISSUE) begin
      alu_op_select = op_q;
      alu_operand1  = a_q[idx*data_size +: data_size];
      alu_operand2  = b_q[idx*data_size +: data_size];
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
